// File: rtl/bus_arbiter_mux.sv
// bus_arbiter_mux: registered N-source bus multiplexer with fixed-priority or round-robin
// arbitration, grant hold, and a saturating request-conflict counter.
module bus_arbiter_mux #(
    parameter int N  = 10,
    parameter int W  = 16,
    parameter int CW = 8,
    localparam int IW = (N < 2) ? 1 : $clog2(N)
) (
    input  logic            clock,
    input  logic            resetn,
    input  logic [N*W-1:0]  src_data,
    input  logic [N-1:0]    src_req,
    input  logic            rr_mode,
    input  logic            hold,
    input  logic            count_clr,
    output logic [W-1:0]    bus,
    output logic            bus_valid,
    output logic [N-1:0]    grant,
    output logic [IW-1:0]   grant_idx,
    output logic            conflict,
    output logic [CW-1:0]   conflict_count
);
    logic [W-1:0]  src [N];
    logic [IW-1:0] last;
    logic [IW-1:0] fp_idx;
    logic [IW-1:0] rr_idx;
    logic [IW-1:0] win;
    logic          hold_ok;
    logic          multi;
    int            pop;

    for (genvar g = 0; g < N; g++) begin : g_src
        assign src[g] = src_data[g*W +: W];
    end

    always_comb begin
        fp_idx = '0;
        for (int i = N - 1; i >= 0; i--)
            if (src_req[i]) fp_idx = IW'(i);
    end

    // Scan backwards so the last hit is the first index after the pointer.
    always_comb begin
        rr_idx = '0;
        for (int k = N; k >= 1; k--)
            if (src_req[(int'(last) + k) % N]) rr_idx = IW'((int'(last) + k) % N);
    end

    always_comb begin
        pop = 0;
        for (int i = 0; i < N; i++) pop += int'(src_req[i]);
    end

    assign multi   = pop >= 2;
    assign hold_ok = hold && bus_valid && src_req[grant_idx];
    assign win     = rr_mode ? rr_idx : fp_idx;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            bus       <= '0;
            bus_valid <= 1'b0;
            grant     <= '0;
            grant_idx <= '0;
            last      <= IW'(N - 1);
        end else if (hold_ok) begin
            bus <= src[grant_idx];
        end else if (!(|src_req)) begin
            bus       <= '0;
            bus_valid <= 1'b0;
            grant     <= '0;
            grant_idx <= '0;
        end else begin
            bus       <= src[win];
            bus_valid <= 1'b1;
            grant     <= {{(N-1){1'b0}}, 1'b1} << win;
            grant_idx <= win;
            last      <= win;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            conflict       <= 1'b0;
            conflict_count <= '0;
        end else begin
            conflict       <= multi;
            conflict_count <= count_clr ? '0 :
                              (multi && conflict_count != '1) ? conflict_count + CW'(1) :
                              conflict_count;
        end
    end
endmodule

// File: tb/tb_bus_arbiter_mux.sv
// tb_bus_arbiter_mux: directed scoreboard bench; a full-width instance and a CW=2 instance
// share the stimulus so counter saturation is observable alongside the main behaviour.
module tb_bus_arbiter_mux;
    logic         clock = 1'b0;
    logic         resetn;
    logic [159:0] src_data;
    logic [9:0]   src_req;
    logic         rr_mode, hold, count_clr;
    logic [15:0]  d [10];
    logic [15:0]  bus, bus2;
    logic         bus_valid, bus_valid2, conflict, conflict2;
    logic [9:0]   grant, grant2;
    logic [3:0]   grant_idx, grant_idx2;
    logic [7:0]   conflict_count;
    logic [1:0]   conflict_count2;

    typedef struct {
        logic [15:0] bus;
        logic        v;
        logic [3:0]  idx;
        logic        c;
        logic [7:0]  cnt;
        logic [1:0]  cnt2;
    } exp_t;

    exp_t       q [$];
    string      nq [$];
    exp_t       e;
    string      n;
    logic [9:0] g;
    int         checks = 0;
    int         passes = 0;

    always #5 clock = ~clock;

    always_comb
        for (int i = 0; i < 10; i++) src_data[i*16 +: 16] = d[i];

    bus_arbiter_mux #(.N(10), .W(16), .CW(8)) dut (
        .clock(clock), .resetn(resetn), .src_data(src_data), .src_req(src_req),
        .rr_mode(rr_mode), .hold(hold), .count_clr(count_clr),
        .bus(bus), .bus_valid(bus_valid), .grant(grant), .grant_idx(grant_idx),
        .conflict(conflict), .conflict_count(conflict_count)
    );

    bus_arbiter_mux #(.N(10), .W(16), .CW(2)) dut2 (
        .clock(clock), .resetn(resetn), .src_data(src_data), .src_req(src_req),
        .rr_mode(rr_mode), .hold(hold), .count_clr(count_clr),
        .bus(bus2), .bus_valid(bus_valid2), .grant(grant2), .grant_idx(grant_idx2),
        .conflict(conflict2), .conflict_count(conflict_count2)
    );

    task automatic push(input string name, input logic [15:0] b, input logic v,
                        input logic [3:0] idx, input logic c, input logic [7:0] cnt,
                        input logic [1:0] cnt2);
        exp_t x;
        x.bus = b; x.v = v; x.idx = idx; x.c = c; x.cnt = cnt; x.cnt2 = cnt2;
        q.push_back(x);
        nq.push_back(name);
    endtask

    task automatic step(input string name, input logic [15:0] b, input logic v,
                        input logic [3:0] idx, input logic c, input logic [7:0] cnt,
                        input logic [1:0] cnt2);
        @(posedge clock);
        #1;
        push(name, b, v, idx, c, cnt, cnt2);
    endtask

    always @(negedge clock) begin
        if (q.size() > 0) begin
            e = q.pop_front();
            n = nq.pop_front();
            g = e.v ? (10'd1 << e.idx) : 10'd0;
            checks++;
            if (bus === e.bus && bus_valid === e.v && grant === g && grant_idx === e.idx &&
                conflict === e.c && conflict_count === e.cnt &&
                bus2 === e.bus && bus_valid2 === e.v && grant2 === g && grant_idx2 === e.idx &&
                conflict2 === e.c && conflict_count2 === e.cnt2)
                passes++;
            else
                $display("FAIL %s: got bus=%h v=%b grant=%h idx=%0d conf=%b cnt=%0d | bus2=%h v2=%b grant2=%h idx2=%0d conf2=%b cnt2=%0d ; want bus=%h v=%b grant=%h idx=%0d conf=%b cnt=%0d cnt2=%0d",
                         n, bus, bus_valid, grant, grant_idx, conflict, conflict_count,
                         bus2, bus_valid2, grant2, grant_idx2, conflict2, conflict_count2,
                         e.bus, e.v, g, e.idx, e.c, e.cnt, e.cnt2);
        end
    end

    initial begin
        for (int i = 0; i < 10; i++) d[i] = {4{4'(i)}};
        d[0] = 16'h0A0A;
        resetn = 1'b0; src_req = '0; rr_mode = 1'b0; hold = 1'b0; count_clr = 1'b0;
        repeat (2) @(posedge clock);
        #1 resetn = 1'b1;
        step("idle_after_reset", 16'h0000, 0, 0, 0, 0, 0);
        src_req = 10'b0000010110;
        step("fixed_prio", 16'h1111, 1, 1, 1, 1, 1);
        @(negedge clock);
        #1;
        resetn = 1'b0; src_req = 10'h004;
        push("async_reset", 16'h0000, 0, 0, 0, 0, 0);
        @(negedge clock);
        step("reset_held", 16'h0000, 0, 0, 0, 0, 0);
        resetn = 1'b1; src_req = '0;
        step("release_idle", 16'h0000, 0, 0, 0, 0, 0);
        rr_mode = 1'b1; src_req = 10'b1000000101;
        step("rr_first_0", 16'h0A0A, 1, 0, 1, 1, 1);
        step("rr_2", 16'h2222, 1, 2, 1, 2, 2);
        step("rr_9", 16'h9999, 1, 9, 1, 3, 3);
        step("rr_wrap_0_sat", 16'h0A0A, 1, 0, 1, 4, 3);
        count_clr = 1'b1;
        step("clr_beats_conflict", 16'h2222, 1, 2, 1, 0, 0);
        count_clr = 1'b0; rr_mode = 1'b0; d[5] = 16'hA5A5; src_req = 10'h020;
        step("grant5", 16'hA5A5, 1, 5, 0, 0, 0);
        hold = 1'b1; src_req = 10'h021;
        step("hold5", 16'hA5A5, 1, 5, 1, 1, 1);
        d[5] = 16'h5A5A;
        step("hold5_resample", 16'h5A5A, 1, 5, 1, 2, 2);
        src_req = 10'h001;
        step("hold_drop_to_0", 16'h0A0A, 1, 0, 0, 2, 2);
        src_req = '0;
        step("hold_idle", 16'h0000, 0, 0, 0, 2, 2);
        hold = 1'b0; src_req = 10'h008; d[3] = 16'h0001;
        step("data3_a", 16'h0001, 1, 3, 0, 2, 2);
        d[3] = 16'h0002;
        step("data3_b", 16'h0002, 1, 3, 0, 2, 2);
        d[3] = 16'h0003;
        step("data3_c", 16'h0003, 1, 3, 0, 2, 2);
        rr_mode = 1'b1;
        step("rr_lone_last", 16'h0003, 1, 3, 0, 2, 2);
        src_req = 10'h00A;
        step("rr_wrap_to_1", 16'h1111, 1, 1, 1, 3, 3);
        rr_mode = 1'b0; src_req = 10'h200;
        step("fixed_top", 16'h9999, 1, 9, 0, 3, 3);
        rr_mode = 1'b1; hold = 1'b1; src_req = 10'h201;
        step("hold_across_mode", 16'h9999, 1, 9, 1, 4, 3);
        hold = 1'b0;
        step("rr_after_hold", 16'h0A0A, 1, 0, 1, 5, 3);
        repeat (2) @(negedge clock);
        #1;
        if (q.size() != 0) begin
            checks++;
            $display("FAIL drain: got %0d pending entries, want 0", q.size());
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
